// File: rtl/control_sequencer.sv
// Multi-cycle fetch/execute sequencer driving the register bank, word memory and 3-input ALU.
// State and architectural registers update on posedge; strobes are decoded combinationally from state.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_FETCH | read instruction word at pc into ir
// S_EXEC  | decode ir: halt, branch, load address, store or ALU write
// S_LOAD  | write the word at the latched effective address to dst
// S_HALT  | absorbing stop state, left only through reset
module control_sequencer #(
    parameter logic [31:0] RESET_PC  = 32'd0,
    parameter int unsigned MEM_DEPTH = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    output logic [31:0] mem_addr,
    output logic        mem_w,
    output logic [31:0] mem_w_v,
    input  logic [31:0] mem_r_v,
    output logic        reg_w,
    output logic [4:0]  reg_dst,
    output logic [4:0]  reg_src1,
    output logic [4:0]  reg_src2,
    output logic [31:0] reg_w_v,
    input  logic [31:0] src1_v,
    input  logic [31:0] src2_v,
    output logic        alu_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [31:0] alu_c,
    input  logic [31:0] alu_out,
    output logic [31:0] pc,
    output logic        halted,
    output logic        fault,
    output logic [31:0] retired
);

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_LOAD, S_HALT} state_t;

    localparam logic [31:0] MEM_LIMIT = MEM_DEPTH;

    state_t      state;
    logic [31:0] ir;
    logic [31:0] ld_ea;

    logic        ir_br, ir_mem, ir_wr, ir_op, ir_hlt;
    logic [31:0] simm;
    logic        fetch_oob, ea_oob, live;
    logic        unused_ir;

    assign ir_br     = ir[24];
    assign ir_mem    = ir[23];
    assign ir_wr     = ir[22];
    assign ir_op     = ir[21];
    assign ir_hlt    = ir[20];
    assign simm      = {{27{ir[19]}}, ir[19:15]};
    assign fetch_oob = pc >= MEM_LIMIT;
    assign ea_oob    = alu_out >= MEM_LIMIT;
    assign unused_ir = ^ir[31:25];

    // Strobes must fall the instant rst rises so a reset mid-EXEC never commits on the negedge.
    assign live = run && !rst;

    always_comb begin
        mem_addr = pc;
        mem_w    = 1'b0;
        mem_w_v  = src2_v;
        reg_w    = 1'b0;
        reg_dst  = ir[14:10];
        reg_src1 = ir[9:5];
        reg_src2 = ir[4:0];
        reg_w_v  = alu_out;
        alu_op   = 1'b1;
        alu_a    = src1_v;
        alu_b    = 32'd0;
        alu_c    = simm;
        case (state)
            S_EXEC: begin
                if (!ir_hlt && !ir_br && ir_mem) begin
                    mem_addr = alu_out;
                    mem_w    = live && !ir_wr && !ea_oob;
                end else if (!ir_hlt && !ir_br && ir_wr) begin
                    alu_op = ir_op;
                    alu_b  = src2_v;
                    reg_w  = live;
                end
            end
            S_LOAD: begin
                mem_addr = ld_ea;
                reg_w_v  = mem_r_v;
                reg_w    = live;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_FETCH;
            pc      <= RESET_PC;
            ir      <= 32'd0;
            ld_ea   <= 32'd0;
            retired <= 32'd0;
            halted  <= 1'b0;
            fault   <= 1'b0;
        end else if (run) begin
            case (state)
                S_FETCH: begin
                    if (fetch_oob) begin
                        fault  <= 1'b1;
                        halted <= 1'b1;
                        state  <= S_HALT;
                    end else begin
                        ir    <= mem_r_v;
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (ir_hlt) begin
                        halted  <= 1'b1;
                        retired <= retired + 32'd1;
                        state   <= S_HALT;
                    end else if (ir_br) begin
                        pc      <= (src1_v == 32'd0) ? pc + simm : pc + 32'd1;
                        retired <= retired + 32'd1;
                        state   <= S_FETCH;
                    end else if (ir_mem && ea_oob) begin
                        fault  <= 1'b1;
                        halted <= 1'b1;
                        state  <= S_HALT;
                    end else if (ir_mem && ir_wr) begin
                        ld_ea <= alu_out;
                        state <= S_LOAD;
                    end else begin
                        pc      <= pc + 32'd1;
                        retired <= retired + 32'd1;
                        state   <= S_FETCH;
                    end
                end
                S_LOAD: begin
                    pc      <= pc + 32'd1;
                    retired <= retired + 32'd1;
                    state   <= S_FETCH;
                end
                default: state <= S_HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: behavioural register bank, memory and ALU around the sequencer,
// a table of single-instruction programs, and hand-written multi-cycle sequences.
module tb_control_sequencer;

    localparam logic [31:0] DEPTH = 32'd4096;
    localparam logic [31:0] HALT_W = 32'h0010_0000;

    logic        clk = 1'b0;
    logic        rst, run;
    logic [31:0] mem_addr, mem_w_v, mem_r_v;
    logic        mem_w, reg_w, alu_op, halted, fault;
    logic [4:0]  reg_dst, reg_src1, reg_src2;
    logic [31:0] reg_w_v, src1_v, src2_v, alu_a, alu_b, alu_c, alu_out, pc, retired;

    logic [31:0] mem  [4096];
    logic [31:0] regs [32];

    typedef struct {
        logic        is_mem;
        logic [31:0] addr;
        logic [31:0] val;
    } wr_t;
    wr_t sb[$];

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] r1v;
        logic [31:0] r2v;
        logic        exp_w;
        logic        w_mem;
        logic [31:0] w_addr;
        logic [31:0] w_val;
        logic [4:0]  chk;
        logic [31:0] chk_v;
        logic [31:0] pc_e;
        int          cyc_e;
        logic        fault_e;
        logic [31:0] ret_e;
    } vec_t;
    vec_t vecs[14];

    int tests = 0;
    int errors = 0;

    control_sequencer dut (
        .clk(clk), .rst(rst), .run(run),
        .mem_addr(mem_addr), .mem_w(mem_w), .mem_w_v(mem_w_v), .mem_r_v(mem_r_v),
        .reg_w(reg_w), .reg_dst(reg_dst), .reg_src1(reg_src1), .reg_src2(reg_src2),
        .reg_w_v(reg_w_v), .src1_v(src1_v), .src2_v(src2_v),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_out(alu_out),
        .pc(pc), .halted(halted), .fault(fault), .retired(retired)
    );

    always #5 clk = ~clk;

    assign mem_r_v = (mem_addr < DEPTH) ? mem[mem_addr[11:0]] : 32'hDEAD_BEEF;
    assign src1_v  = (reg_src1 == 5'd0) ? 32'd0 : regs[reg_src1];
    assign src2_v  = (reg_src2 == 5'd0) ? 32'd0 : regs[reg_src2];
    assign alu_out = alu_op ? alu_a + alu_b + alu_c : alu_a - alu_b + alu_c;

    function automatic logic [31:0] enc(input logic br, input logic mm, input logic wr,
                                        input logic op, input logic hlt, input logic [4:0] imm,
                                        input logic [4:0] dst, input logic [4:0] s1,
                                        input logic [4:0] s2);
        return {7'd0, br, mm, wr, op, hlt, imm, dst, s1, s2};
    endfunction

    function automatic logic [31:0] rd(input logic [4:0] idx);
        return (idx == 5'd0) ? 32'd0 : regs[idx];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: the negedge commits (and scores) any write, then return just after the posedge.
    task automatic tick();
        wr_t e;
        @(negedge clk);
        if (reg_w) begin
            if (sb.size() == 0) begin
                tests++; errors++;
                $display("FAIL unexpected_reg_write: got r%0d=%h expected no write", reg_dst, reg_w_v);
            end else begin
                e = sb.pop_front();
                check("reg_write_dst", {27'd0, reg_dst}, e.is_mem ? 32'hFFFF_FFFF : e.addr);
                check("reg_write_val", reg_w_v, e.val);
            end
            regs[reg_dst] = reg_w_v;
        end
        if (mem_w) begin
            if (sb.size() == 0) begin
                tests++; errors++;
                $display("FAIL unexpected_mem_write: got [%h]=%h expected no write", mem_addr, mem_w_v);
            end else begin
                e = sb.pop_front();
                check("mem_write_addr", mem_addr, e.is_mem ? e.addr : 32'hFFFF_FFFF);
                check("mem_write_val", mem_w_v, e.val);
            end
            if (mem_addr < DEPTH) mem[mem_addr[11:0]] = mem_w_v;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic setup(input logic [31:0] r1v, input logic [31:0] r2v);
        for (int i = 0; i < 4096; i++) mem[i] = HALT_W;
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        regs[1] = r1v;
        regs[2] = r2v;
        sb.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        run = 1'b0;
        tick();
        check("reset_pc", pc, 32'd0);
        check("reset_flags", {29'd0, halted, fault, reg_w | mem_w}, 32'd0);
        rst = 1'b0;
    endtask

    task automatic run_until_halt(input int budget, inout int cyc);
        run = 1'b1;
        while (!halted && cyc < budget) begin
            tick();
            cyc++;
        end
        if (!halted) begin
            tests++; errors++;
            $display("FAIL halt_timeout: got no halt after %0d cycles expected halted", cyc);
        end
    endtask

    initial begin
        int cyc;
        wr_t w;

        vecs[0]  = '{"alu_add",      enc(0,0,1,1,0,5'd2,5'd3,5'd1,5'd2),   32'd10,   32'd5, 1'b1, 1'b0, 32'd3,    32'd17,       5'd3, 32'd17,       32'd1,        4, 1'b0, 32'd2};
        vecs[1]  = '{"alu_sub",      enc(0,0,1,0,0,5'h1F,5'd4,5'd1,5'd2),  32'd10,   32'd5, 1'b1, 1'b0, 32'd4,    32'd4,        5'd4, 32'd4,        32'd1,        4, 1'b0, 32'd2};
        vecs[2]  = '{"alu_sub_wrap", enc(0,0,1,0,0,5'd0,5'd6,5'd1,5'd2),   32'd0,    32'd1, 1'b1, 1'b0, 32'd6,    32'hFFFFFFFF, 5'd6, 32'hFFFFFFFF, 32'd1,        4, 1'b0, 32'd2};
        vecs[3]  = '{"alu_r0",       enc(0,0,1,1,0,5'd3,5'd0,5'd1,5'd2),   32'd1,    32'd1, 1'b1, 1'b0, 32'd0,    32'd5,        5'd0, 32'd0,        32'd1,        4, 1'b0, 32'd2};
        vecs[4]  = '{"nop",          32'd0,                                 32'd7,    32'd0, 1'b0, 1'b0, 32'd0,    32'd0,        5'd1, 32'd7,        32'd1,        4, 1'b0, 32'd2};
        vecs[5]  = '{"br_taken",     enc(1,0,0,0,0,5'd3,5'd0,5'd0,5'd0),   32'd7,    32'd0, 1'b0, 1'b0, 32'd0,    32'd0,        5'd1, 32'd7,        32'd3,        4, 1'b0, 32'd2};
        vecs[6]  = '{"br_not_taken", enc(1,0,0,0,0,5'd3,5'd0,5'd1,5'd0),   32'd7,    32'd0, 1'b0, 1'b0, 32'd0,    32'd0,        5'd1, 32'd7,        32'd1,        4, 1'b0, 32'd2};
        vecs[7]  = '{"hlt_priority", enc(1,1,1,1,1,5'd3,5'd7,5'd0,5'd0),   32'd0,    32'd0, 1'b0, 1'b0, 32'd0,    32'd0,        5'd7, 32'd0,        32'd0,        2, 1'b0, 32'd1};
        vecs[8]  = '{"br_over_wr",   enc(1,0,1,1,0,5'd2,5'd7,5'd0,5'd0),   32'd0,    32'd0, 1'b0, 1'b0, 32'd0,    32'd0,        5'd7, 32'd0,        32'd2,        4, 1'b0, 32'd2};
        vecs[9]  = '{"st_oob",       enc(0,1,0,1,0,5'd0,5'd0,5'd1,5'd2),   32'd4096, 32'd9, 1'b0, 1'b0, 32'd0,    32'd0,        5'd2, 32'd9,        32'd0,        2, 1'b1, 32'd0};
        vecs[10] = '{"ld_oob",       enc(0,1,1,1,0,5'd1,5'd3,5'd1,5'd0),   32'd4095, 32'd0, 1'b0, 1'b0, 32'd0,    32'd0,        5'd3, 32'd0,        32'd0,        2, 1'b1, 32'd0};
        vecs[11] = '{"br_neg_fault", enc(1,0,0,0,0,5'h1F,5'd0,5'd0,5'd0),  32'd0,    32'd0, 1'b0, 1'b0, 32'd0,    32'd0,        5'd1, 32'd0,        32'hFFFFFFFF, 3, 1'b1, 32'd1};
        vecs[12] = '{"ld_edge",      enc(0,1,1,1,0,5'd0,5'd3,5'd1,5'd0),   32'd4095, 32'd0, 1'b1, 1'b0, 32'd3,    HALT_W,       5'd3, HALT_W,       32'd1,        5, 1'b0, 32'd2};
        vecs[13] = '{"st_edge",      enc(0,1,0,1,0,5'd0,5'd0,5'd1,5'd2),   32'd4095, 32'd9, 1'b1, 1'b1, 32'd4095, 32'd9,        5'd1, 32'd4095,     32'd1,        4, 1'b0, 32'd2};

        rst = 1'b1;
        run = 1'b0;

        for (int v = 0; v < 14; v++) begin
            setup(vecs[v].r1v, vecs[v].r2v);
            mem[0] = vecs[v].instr;
            if (vecs[v].exp_w) begin
                w = '{vecs[v].w_mem, vecs[v].w_addr, vecs[v].w_val};
                sb.push_back(w);
            end
            do_reset();
            cyc = 0;
            run_until_halt(20, cyc);
            check({vecs[v].name, "/halted"},  {31'd0, halted}, 32'd1);
            check({vecs[v].name, "/fault"},   {31'd0, fault}, {31'd0, vecs[v].fault_e});
            check({vecs[v].name, "/pc"},      pc, vecs[v].pc_e);
            check({vecs[v].name, "/retired"}, retired, vecs[v].ret_e);
            check({vecs[v].name, "/cycles"},  cyc, vecs[v].cyc_e);
            check({vecs[v].name, "/reg"},     rd(vecs[v].chk), vecs[v].chk_v);
            check({vecs[v].name, "/sb_left"}, sb.size(), 32'd0);
        end

        // r1 = 0+0+1, r2 = r1+r1+1, halt
        setup(32'd0, 32'd0);
        mem[0] = enc(0,0,1,1,0,5'd1,5'd1,5'd0,5'd0);
        mem[1] = enc(0,0,1,1,0,5'd1,5'd2,5'd1,5'd1);
        sb.push_back('{1'b0, 32'd1, 32'd1});
        sb.push_back('{1'b0, 32'd2, 32'd3});
        do_reset();
        cyc = 0;
        run_until_halt(20, cyc);
        check("prog/r1", rd(5'd1), 32'd1);
        check("prog/r2", rd(5'd2), 32'd3);
        check("prog/retired", retired, 32'd3);
        check("prog/pc", pc, 32'd2);
        check("prog/cycles", cyc, 32'd6);

        // Same program, frozen for 5 cycles while EXEC of the second write is pending.
        setup(32'd0, 32'd0);
        mem[0] = enc(0,0,1,1,0,5'd1,5'd1,5'd0,5'd0);
        mem[1] = enc(0,0,1,1,0,5'd1,5'd2,5'd1,5'd1);
        sb.push_back('{1'b0, 32'd1, 32'd1});
        sb.push_back('{1'b0, 32'd2, 32'd3});
        do_reset();
        run = 1'b1;
        cyc = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            cyc++;
        end
        run = 1'b0;
        #1;
        check("hold/strobe_drop", {31'd0, reg_w}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold/strobes", {30'd0, reg_w, mem_w}, 32'd0);
        end
        check("hold/pc", pc, 32'd1);
        check("hold/retired", retired, 32'd1);
        check("hold/r2", rd(5'd2), 32'd0);
        run_until_halt(20, cyc);
        check("hold/r2_after", rd(5'd2), 32'd3);
        check("hold/retired_after", retired, 32'd3);
        check("hold/pc_after", pc, 32'd2);
        check("hold/active_cycles", cyc, 32'd6);

        // Store r2 to [r5+0], load it back into r3.
        setup(32'd0, 32'd3);
        regs[5] = 32'd100;
        mem[0] = enc(0,1,0,1,0,5'd0,5'd0,5'd5,5'd2);
        mem[1] = enc(0,1,1,1,0,5'd0,5'd3,5'd5,5'd0);
        sb.push_back('{1'b1, 32'd100, 32'd3});
        sb.push_back('{1'b0, 32'd3, 32'd3});
        do_reset();
        run = 1'b1;
        cyc = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            cyc++;
        end
        check("ldst/load_addr", mem_addr, 32'd100);
        check("ldst/load_strobe", {31'd0, reg_w}, 32'd1);
        check("ldst/load_pc", pc, 32'd1);
        run_until_halt(20, cyc);
        check("ldst/mem100", mem[100], 32'd3);
        check("ldst/r3", rd(5'd3), 32'd3);
        check("ldst/retired", retired, 32'd3);
        check("ldst/cycles", cyc, 32'd7);

        // 0: br r0 +4; 4: br r1 -1 (taken while r1==0); 3: r1=1; 4 again: not taken -> 5: halt.
        setup(32'd0, 32'd0);
        mem[0] = enc(1,0,0,0,0,5'd4,5'd0,5'd0,5'd0);
        mem[4] = enc(1,0,0,0,0,5'h1F,5'd0,5'd1,5'd0);
        mem[3] = enc(0,0,1,1,0,5'd1,5'd1,5'd0,5'd0);
        sb.push_back('{1'b0, 32'd1, 32'd1});
        do_reset();
        run = 1'b1;
        cyc = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            cyc++;
        end
        check("branch/back_pc", pc, 32'd3);
        run_until_halt(30, cyc);
        check("branch/final_pc", pc, 32'd5);
        check("branch/retired", retired, 32'd5);
        check("branch/cycles", cyc, 32'd10);

        // Reset arrives during EXEC of a write to r4.
        setup(32'd0, 32'd0);
        regs[4] = 32'h55;
        mem[0] = enc(0,0,1,1,0,5'd5,5'd4,5'd0,5'd0);
        do_reset();
        run = 1'b1;
        tick();
        check("rstmid/strobe_before", {31'd0, reg_w}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("rstmid/strobe_drop", {31'd0, reg_w}, 32'd0);
        check("rstmid/pc", pc, 32'd0);
        check("rstmid/retired", retired, 32'd0);
        tick();
        check("rstmid/r4_kept", rd(5'd4), 32'h55);
        rst = 1'b0;
        sb.push_back('{1'b0, 32'd4, 32'd5});
        cyc = 0;
        run_until_halt(20, cyc);
        check("rstmid/restart_cycles", cyc, 32'd4);
        check("rstmid/r4_after", rd(5'd4), 32'd5);
        check("rstmid/retired_after", retired, 32'd2);
        check("rstmid/sb_left", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Multi-cycle fetch/execute sequencer: the initiator that drives the existing register bank, word memory and 3-input ALU.
- Fetches an instruction word from memory at PC, decodes it, drives register read/write and ALU operands, and performs loads, stores and branches.
- Sits at the top of the core, between the three datapath blocks.

Parameters:
- RESET_PC, 0, PC value loaded on reset.
- MEM_DEPTH, 4096, number of valid memory words; any fetch or data address >= MEM_DEPTH is a fault.

Ports:
- clk  input  1  core clock; FSM updates on posedge. Register bank and memory commit writes on negedge.
- rst  input  1  asynchronous, active-high reset.
- run  input  1  when low, FSM holds state; no strobes asserted.
- mem_addr  output  32  memory word address.
- mem_w  output  1  memory write strobe.
- mem_w_v  output  32  memory write data.
- mem_r_v  input  32  memory read data, combinational from mem_addr.
- reg_w  output  1  register write strobe.
- reg_dst  output  5  destination register index.
- reg_src1  output  5  source 1 register index.
- reg_src2  output  5  source 2 register index.
- reg_w_v  output  32  register write data.
- src1_v  input  32  value of reg_src1; r0 reads 0.
- src2_v  input  32  value of reg_src2; r0 reads 0.
- alu_op  output  1  1 = a+b+c, 0 = a-b+c.
- alu_a  output  32  ALU operand a.
- alu_b  output  32  ALU operand b.
- alu_c  output  32  ALU operand c.
- alu_out  input  32  ALU result.
- pc  output  32  current program counter.
- halted  output  1  high in HALT.
- fault  output  1  high when HALT was entered on an address fault.
- retired  output  32  count of completed instructions.

Behaviour:
- Instruction fields:
  - [31:25] ignored.
  - [24] br, [23] mem, [22] wr, [21] op, [20] hlt.
  - [19:15] imm5, [14:10] dst, [9:5] src1, [4:0] src2.
  - simm = imm5 sign-extended to 32 bits.
- Reset (async, immediate): state=FETCH, pc=RESET_PC, ir=0, retired=0, halted=0, fault=0. All strobes 0; strobes drop combinationally when rst rises.
- States: FETCH, EXEC, LOAD, HALT. Transitions occur only on a posedge with run=1.
- FETCH:
  - mem_addr=pc, mem_w=0, reg_w=0.
  - If pc>=MEM_DEPTH: fault=1, go to HALT.
  - Otherwise ir<=mem_r_v, go to EXEC.
- EXEC: reg_src1=ir.src1, reg_src2=ir.src2, alu_a=src1_v, alu_c=simm. Decode priority: hlt > br > mem > wr.
  - hlt: go to HALT; retired increments.
  - br: if src1_v==0 then pc<=pc+simm, else pc<=pc+1. Go to FETCH.
  - mem & wr (load): alu_op=1, alu_b=0, mem_addr=alu_out. If the address is out of range: fault, HALT. Otherwise go to LOAD.
  - mem & !wr (store): alu_op=1, alu_b=0, mem_addr=alu_out, mem_w_v=src2_v. mem_w=1 only if the address is in range; otherwise fault, HALT. pc<=pc+1, go to FETCH.
  - wr only (ALU): alu_op=ir.op, alu_b=src2_v, reg_dst=dst, reg_w_v=alu_out, reg_w=1. pc<=pc+1, go to FETCH.
  - no flag set: NOP; pc<=pc+1, go to FETCH.
- LOAD: mem_addr holds the effective address. reg_dst=dst, reg_w_v=mem_r_v, reg_w=1. pc<=pc+1, go to FETCH.
- Latency: ALU, store, branch and NOP take 2 cycles; load takes 3.
- retired increments on each transition out of EXEC or LOAD that completes an instruction. Fault exits do not count. The counter wraps modulo 2^32.
- Write strobes:
  - Asserted for the whole state with run=1 and no fault; while run=0 they are 0.
  - Writes to dst=0 are still issued; the register bank ignores them on read.
- HALT: absorbing, all strobes 0, pc frozen; exit only by reset.
- pc arithmetic is modulo 2^32. A branch to a negative pc wraps and faults on the next FETCH.
- Reset mid-EXEC with reg_w or mem_w high: strobe drops before the negedge, so no write occurs.

Test Plan:
- Memory[0..3] = ALU r1=0+0+1, ALU r2=r1+r1+1, HALT; pulse rst -> r1=1, r2=3, halted=1, retired=3, pc=2, 6 cycles to HALT.
- Store r2 (=3) to addr 100 (src1=r0, imm would overflow 5 bits, so use src1=r5 preloaded 100 with simm=0), then load into r3 -> mem[100]=3, r3=3, load EXEC->LOAD->FETCH takes 3 cycles.
- Branch br with src1=r0, imm=11111 at pc=4 -> pc=3 next FETCH; branch with src1=r1 (nonzero) -> pc=5.
- Load with effective address 4096 -> fault=1, halted=1, reg_w never asserted, retired unchanged.
- Hold run=0 for 5 cycles mid-program -> pc, retired, state unchanged, strobes 0; resume gives identical results.
- Assert rst during the EXEC of an ALU write to r4 -> r4 unchanged, pc=RESET_PC, retired=0, FSM in FETCH.
